// File: rtl/multi_key_debouncer.sv
// multi_key_debouncer: CH-channel synchronised push-button debouncer with press/release pulses.
// Optional long-press pulse when LONG_PRESS_EN is defined; otherwise long_pulse is tied to 0.
module multi_key_debouncer #(
    parameter int CH         = 4,
    parameter int CLK_KHZ    = 50000,
    parameter int DEB_MS     = 20,
    parameter int LONG_MS    = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] key_level,
    output logic [CH-1:0] press_pulse,
    output logic [CH-1:0] release_pulse,
    output logic [CH-1:0] long_pulse
);
    localparam int DEB_CYC  = CLK_KHZ * DEB_MS;
    localparam int LONG_CYC = CLK_KHZ * LONG_MS;
    localparam int MAX_CYC  = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
    localparam int CW       = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic INACT = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {RELEASED, P_WAIT, PRESSED, R_WAIT} state_t;

    logic [CH-1:0] s1, s2, p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= {CH{INACT}};
            s2 <= {CH{INACT}};
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    assign p = s2 ^ {CH{INACT}};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t        st, st_n;
        logic [CW-1:0] cnt, cnt_n;
        logic          lvl, prs, rls, lvl_n, prs_n, rls_n;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st  <= RELEASED;
                cnt <= '0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rls <= 1'b0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
                lvl <= lvl_n;
                prs <= prs_n;
                rls <= rls_n;
            end
        end

        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            case (st)
                RELEASED: if (p[i]) begin
                    st_n  = P_WAIT;
                    cnt_n = '0;
                end
                P_WAIT: if (!p[i]) st_n = RELEASED;
                    else if (cnt == DEB_LAST) st_n = PRESSED;
                    else cnt_n = cnt + 1'b1;
                PRESSED: if (!p[i]) begin
                    st_n  = R_WAIT;
                    cnt_n = '0;
                end
                default: if (p[i]) st_n = PRESSED;
                    else if (cnt == DEB_LAST) st_n = RELEASED;
                    else cnt_n = cnt + 1'b1;
            endcase
        end

        always_comb begin
            prs_n = (st == P_WAIT) && p[i] && (cnt == DEB_LAST);
            rls_n = (st == R_WAIT) && !p[i] && (cnt == DEB_LAST);
            lvl_n = prs_n ? 1'b1 : rls_n ? 1'b0 : lvl;
        end

        assign key_level[i]     = lvl;
        assign press_pulse[i]   = prs;
        assign release_pulse[i] = rls;

`ifdef LONG_PRESS_EN
        localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
        localparam logic [CW-1:0] LONG_DONE = CW'(LONG_CYC);
        logic [CW-1:0] lcnt;
        logic          lp, held;

        assign held = (st == PRESSED) || (st == R_WAIT);

        // Counter parks one past the threshold so the pulse fires once per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lcnt <= '0;
                lp   <= 1'b0;
            end else begin
                lcnt <= !held ? '0 : (lcnt == LONG_DONE) ? lcnt : lcnt + 1'b1;
                lp   <= held && (lcnt == LONG_LAST);
            end
        end

        assign long_pulse[i] = lp;
`else
        assign long_pulse[i] = 1'b0;
`endif
    end
endmodule
